// File: rtl/shot_move_controller.sv
// Player shot position generator: launches on a fire-button rising edge, climbs once per frame,
// retires on collision or top-of-screen exit, then waits out a frame cooldown before re-arming.
module shot_move_controller #(
    parameter int SHOT_SPEED_Y    = 4,
    parameter int SHOT_WIDTH      = 4,
    parameter int SHOT_HEIGHT     = 8,
    parameter int PLAYER_WIDTH    = 32,
    parameter int PLAYER_Y        = 420,
    parameter int TOP_LIMIT       = 0,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start_of_frame,
    input  logic               i_shot_press,
    input  logic signed [10:0] i_player_pos_x,
    input  logic               i_collision,
    output logic signed [10:0] o_top_left_x,
    output logic signed [10:0] o_top_left_y,
    output logic               o_shot_active,
    output logic               o_shot_fired
);

    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic signed [10:0] X_OFFSET = 11'((PLAYER_WIDTH - SHOT_WIDTH) / 2);
    localparam logic signed [10:0] LAUNCH_Y = 11'(PLAYER_Y - SHOT_HEIGHT);
    localparam logic signed [10:0] SPEED_Y  = 11'(SHOT_SPEED_Y);
    localparam logic signed [10:0] EXIT_Y   = 11'(TOP_LIMIT - SHOT_HEIGHT);

    typedef enum logic [1:0] {StIdle, StFlying, StCooldown} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic               r_prev_press;
    logic signed [10:0] r_x;
    logic signed [10:0] w_x_d;
    logic signed [10:0] r_y;
    logic signed [10:0] w_y_d;
    logic               r_active;
    logic               w_active_d;
    logic               r_fired;
    logic               w_fired_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_d;
    logic               w_press_edge;
    logic signed [10:0] w_y_step;

    assign w_press_edge = i_shot_press & ~r_prev_press;
    assign w_y_step     = r_y - SPEED_Y;

    // Press history resets high so a button held through reset cannot fire.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_prev_press <= 1'b1;
            r_x          <= '0;
            r_y          <= '0;
            r_active     <= 1'b0;
            r_fired      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_d;
            r_prev_press <= i_shot_press;
            r_x          <= w_x_d;
            r_y          <= w_y_d;
            r_active     <= w_active_d;
            r_fired      <= w_fired_d;
            r_cnt        <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_x_d      = r_x;
        w_y_d      = r_y;
        w_active_d = r_active;
        w_fired_d  = 1'b0;
        w_cnt_d    = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_press_edge) begin
                    w_x_d      = i_player_pos_x + X_OFFSET;
                    w_y_d      = LAUNCH_Y;
                    w_active_d = 1'b1;
                    w_fired_d  = 1'b1;
                    w_state_d  = StFlying;
                end
            end
            StFlying: begin
                // Collision takes priority and suppresses the frame's Y step.
                if (i_collision) begin
                    w_active_d = 1'b0;
                    w_cnt_d    = CNT_LOAD;
                    w_state_d  = StCooldown;
                end else if (i_start_of_frame) begin
                    w_y_d = w_y_step;
                    if (w_y_step <= EXIT_Y) begin
                        w_active_d = 1'b0;
                        w_cnt_d    = CNT_LOAD;
                        w_state_d  = StCooldown;
                    end
                end
            end
            StCooldown: begin
                if (r_cnt == '0) begin
                    w_state_d = StIdle;
                end else if (i_start_of_frame) begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_top_left_x  = r_x;
    assign o_top_left_y  = r_y;
    assign o_shot_active = r_active;
    assign o_shot_fired  = r_fired;

endmodule

// File: tb/tb_shot_move_controller.sv
// Self-checking bench for shot_move_controller: a directed vector table plus hand-written
// sequences for full flight, same-cycle collision/frame, held button and mid-flight reset.
module tb_shot_move_controller;

    logic               clk;
    logic               rst_n;
    logic               sof;
    logic               press;
    logic signed [10:0] pos_x;
    logic               coll;
    logic signed [10:0] top_x;
    logic signed [10:0] top_y;
    logic               active;
    logic               fired;

    int n_checks = 0;
    int n_errors = 0;

    shot_move_controller dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start_of_frame(sof),
        .i_shot_press    (press),
        .i_player_pos_x  (pos_x),
        .i_collision     (coll),
        .o_top_left_x    (top_x),
        .o_top_left_y    (top_y),
        .o_shot_active   (active),
        .o_shot_fired    (fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic     sof;
        logic     press;
        int       pos_x;
        logic     coll;
        int       exp_x;
        int       exp_y;
        logic     exp_active;
        logic     exp_fired;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulses on sof/coll; press is a level that persists.
    task automatic step(input logic s, input logic p, input logic c);
        sof   = s;
        press = p;
        coll  = c;
        tick();
        sof  = 1'b0;
        coll = 1'b0;
    endtask

    task automatic add(input logic s, input logic p, input int px, input logic c,
                       input int ex, input int ey, input logic ea, input logic ef);
        vec_t v;
        v.sof = s; v.press = p; v.pos_x = px; v.coll = c;
        v.exp_x = ex; v.exp_y = ey; v.exp_active = ea; v.exp_fired = ef;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sof = 1'b0; press = 1'b0; coll = 1'b0; pos_x = '0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic launch(input int px, input string name);
        pos_x = 11'(px);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check({name, "_fired"}, int'(fired), 1);
        press = 1'b0;
    endtask

    int fire_count;
    logic stayed_active;

    initial begin
        rst_n = 1'b1;
        do_reset();
        check("reset_x", int'(top_x), 0);
        check("reset_y", int'(top_y), 0);
        check("reset_active", int'(active), 0);
        check("reset_fired", int'(fired), 0);

        // Table: launch, move, frozen X, same-cycle collision, cooldown, relaunch.
        add(0, 0, 300, 0,   0,   0, 0, 0);
        add(0, 1, 300, 0, 314, 412, 1, 1);
        add(0, 0, 300, 0, 314, 412, 1, 0);
        add(1, 0, 300, 0, 314, 408, 1, 0);
        add(0, 1, 300, 0, 314, 408, 1, 0);
        add(0, 0, 100, 0, 314, 408, 1, 0);
        add(1, 0, 100, 1, 314, 408, 0, 0);
        add(0, 1, 100, 0, 314, 408, 0, 0);
        add(0, 0, 100, 0, 314, 408, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 0, 100, 0, 314, 408, 0, 0);
        add(0, 0, 100, 0, 314, 408, 0, 0);
        add(0, 1, 100, 0, 114, 412, 1, 1);
        add(0, 1, 100, 0, 114, 412, 1, 0);
        add(0, 0, 100, 1, 114, 412, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            pos_x = 11'(vecs[i].pos_x);
            step(vecs[i].sof, vecs[i].press, vecs[i].coll);
            check($sformatf("vec%0d_x", i), int'(top_x), vecs[i].exp_x);
            check($sformatf("vec%0d_y", i), int'(top_y), vecs[i].exp_y);
            check($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].exp_active));
            check($sformatf("vec%0d_fired", i), int'(fired), int'(vecs[i].exp_fired));
        end

        // Full flight to the top of the screen, then cooldown with an ignored press.
        do_reset();
        launch(300, "flight");
        check("flight_launch_x", int'(top_x), 314);
        check("flight_launch_y", int'(top_y), 412);
        step(1'b0, 1'b0, 1'b0);
        check("flight_fired_one_cycle", int'(fired), 0);
        stayed_active = 1'b1;
        for (int i = 1; i <= 105; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i <= 104 && !active) stayed_active = 1'b0;
            if (i == 1)   check("flight_y_1", int'(top_y), 408);
            if (i == 102) check("flight_y_102", int'(top_y), 4);
            if (i == 104) check("flight_y_104", int'(top_y), -4);
            if (i == 105) begin
                check("flight_exit_active", int'(active), 0);
                check("flight_exit_y", int'(top_y), -8);
            end
        end
        check("flight_active_through_104", int'(stayed_active), 1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("cooldown_press_ignored", int'(fired), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("rearm_fired", int'(fired), 1);
        check("rearm_y", int'(top_y), 412);
        press = 1'b0;

        // Collision and frame pulse together at Y=200.
        do_reset();
        launch(50, "sc");
        for (int i = 0; i < 53; i++) step(1'b1, 1'b0, 1'b0);
        check("sc_y_before", int'(top_y), 200);
        check("sc_x", int'(top_x), 64);
        step(1'b1, 1'b0, 1'b1);
        check("sc_active", int'(active), 0);
        check("sc_y_hold", int'(top_y), 200);

        // Button held for 500 cycles across flight and cooldown fires once.
        do_reset();
        pos_x = 11'(300);
        step(1'b0, 1'b0, 1'b0);
        fire_count = 0;
        for (int i = 0; i < 500; i++) begin
            step((i % 4) == 3, 1'b1, 1'b0);
            if (fired) fire_count++;
        end
        check("held_fire_count", fire_count, 1);
        check("held_inactive_at_end", int'(active), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("held_second_launch", int'(fired), 1);
        press = 1'b0;

        // Reset mid-flight with the button held.
        do_reset();
        launch(300, "mid");
        for (int i = 0; i < 28; i++) step(1'b1, 1'b0, 1'b0);
        check("mid_y_300", int'(top_y), 300);
        press = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_x", int'(top_x), 0);
        check("mid_reset_y", int'(top_y), 0);
        check("mid_reset_active", int'(active), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fire_count = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (fired || active) fire_count++;
        end
        check("mid_no_launch_while_held", fire_count, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("mid_relaunch", int'(fired), 1);
        press = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
